// File: rtl/combi_pkg.sv
// Shared types and constants for the combined ARM/RISC-V fetch stage.
package combi_pkg;

  localparam int unsigned FETCH_DEPTH  = 2;
  localparam logic [31:0] INSTR_BUBBLE = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/combi_fetch_fifo.sv
// Two-entry synchronous FIFO of fetched {instr, pc} pairs. Clear overrides push/pop.
module combi_fetch_fifo
  import combi_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  localparam logic [1:0] FULL = 2'(FETCH_DEPTH);

  fetch_entry_t mem [FETCH_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop & (count != '0);
    do_push = push & ((count != FULL) | do_pop);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ~rd_ptr;
      if (do_push) wr_ptr <= ~wr_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/combi_fetch.sv
// Instruction fetch stage: credit-limited word fetches, 2-entry return buffer,
// decode register with bypass, ISA mode tracking and stale-response discard.
module combi_fetch
  import combi_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic        RESET_ARM = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        redirect_arm,
  input  logic        stallD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        armD,
  output logic        wasNotFlushedD,
  input  logic        arm_dec
);

  logic [31:0]  pc;
  logic         mode;
  logic [1:0]   inflight;
  logic [1:0]   discard;
  logic         grant;
  logic         accept;
  logic         push;
  logic         pop;
  logic [31:0]  rsp_pc;
  fetch_entry_t head;
  logic [1:0]   count;

  always_comb begin
    imem_req  = reset_n & ~redirect_valid & ((3'(inflight) + 3'(count)) < 3'd2);
    imem_addr = pc;
    grant     = imem_req & imem_gnt;
    accept    = imem_rvalid & ~redirect_valid & (discard == '0);
    pop       = ~redirect_valid & ~stallD & (count != '0);
    push      = accept & (stallD | (count != '0));
    // Accepted responses only occur with no stale fetches pending, so every
    // in-flight request is sequential and the oldest one sits at pc - 4*inflight.
    rsp_pc    = pc - {28'b0, inflight, 2'b00};
  end

  combi_fetch_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .clear   (redirect_valid),
    .din     ('{instr: imem_rdata, pc: rsp_pc}),
    .head    (head),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      mode     <= RESET_ARM;
      inflight <= '0;
      discard  <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      mode     <= redirect_arm;
      inflight <= inflight - {1'b0, imem_rvalid};
      discard  <= inflight - {1'b0, imem_rvalid};
    end else begin
      if (grant) pc <= pc + 32'd4;
      inflight <= inflight + {1'b0, grant} - {1'b0, imem_rvalid};
      if (imem_rvalid && discard != '0) discard <= discard - 2'd1;
      if (wasNotFlushedD && !stallD) mode <= arm_dec;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instrD         <= INSTR_BUBBLE;
      pcD            <= '0;
      wasNotFlushedD <= 1'b0;
    end else if (redirect_valid) begin
      instrD         <= INSTR_BUBBLE;
      wasNotFlushedD <= 1'b0;
    end else if (!stallD) begin
      if (count != '0) begin
        instrD         <= head.instr;
        pcD            <= head.pc;
        wasNotFlushedD <= 1'b1;
      end else if (accept) begin
        instrD         <= imem_rdata;
        pcD            <= rsp_pc;
        wasNotFlushedD <= 1'b1;
      end else begin
        instrD         <= INSTR_BUBBLE;
        wasNotFlushedD <= 1'b0;
      end
    end
  end

  assign armD = mode;

endmodule

// File: tb/tb_combi_fetch.sv
// Self-checking bench for combi_fetch: in-order memory model with random
// grant/latency, and a queue-based reference model of the fetch stage.
module tb_combi_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_arm;
  logic        stallD;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        armD;
  logic        wasNotFlushedD;
  logic        arm_dec;

  always #5 clk = ~clk;

  combi_fetch #(.RESET_PC(32'h100), .RESET_ARM(1'b1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .redirect_arm   (redirect_arm),
    .stallD         (stallD),
    .instrD         (instrD),
    .pcD            (pcD),
    .armD           (armD),
    .wasNotFlushedD (wasNotFlushedD),
    .arm_dec        (arm_dec)
  );

  int n_vec  = 0;
  int n_fail = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // memory: pending granted addresses with earliest response cycle
  typedef struct { logic [31:0] a; int rdy; } mreq_t;
  mreq_t mq[$];
  int    lat_max;

  // reference model: outstanding fetches tagged with a redirect epoch
  typedef struct { logic [31:0] pc; int ep; } oreq_t;
  typedef struct { logic [31:0] w; logic [31:0] pc; } fe_t;
  oreq_t       oq[$];
  fe_t         fq[$];
  logic [31:0] m_pc, d_instr, d_pc;
  logic        m_mode, d_wnf;
  int          m_ep, cyc, grants;
  logic        last_req;
  logic [31:0] last_addr;

  task automatic model_reset();
    m_pc = 32'h100; m_mode = 1'b1; m_ep = 0;
    oq.delete(); fq.delete(); mq.delete();
    d_instr = '0; d_pc = '0; d_wnf = 1'b0;
  endtask

  task automatic check_dec();
    chk("instrD", instrD, d_instr);
    chk("pcD", pcD, d_pc);
    chk("wasNotFlushedD", 32'(wasNotFlushedD), 32'(d_wnf));
    chk("armD", 32'(armD), 32'(m_mode));
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rp, input bit ra,
                      input bit gn, input bit rv_en, input bit ad);
    bit          exp_req, rv, hs, acc;
    oreq_t       o;
    fe_t         e, h;
    logic [31:0] hs_addr;
    stallD = st; redirect_valid = rd; redirect_pc = rp; redirect_arm = ra;
    imem_gnt = gn; arm_dec = ad;
    rv = rv_en && mq.size() > 0 && mq[0].rdy <= cyc;
    imem_rvalid = rv;
    imem_rdata  = rv ? memf(mq[0].a) : $urandom();
    #1;
    exp_req = (oq.size() + fq.size() < 2) && !rd;
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_pc);
    last_req = imem_req; last_addr = imem_addr;
    hs = imem_req && gn; hs_addr = imem_addr;
    acc = 1'b0;
    o = '{32'h0, 0};
    if (rv && oq.size() > 0) begin
      o = oq.pop_front();
      acc = !rd && o.ep == m_ep;
    end
    e = '{memf(o.pc), o.pc};
    if (rd) begin
      fq.delete(); m_pc = rp; m_mode = ra; m_ep++;
      d_instr = '0; d_wnf = 1'b0;
    end else begin
      if (exp_req && gn) begin
        oq.push_back('{m_pc, m_ep}); m_pc += 32'd4; grants++;
      end
      if (d_wnf && !st) m_mode = ad;
      if (!st) begin
        if (fq.size() > 0) begin
          h = fq.pop_front(); d_instr = h.w; d_pc = h.pc; d_wnf = 1'b1;
          if (acc) fq.push_back(e);
        end else if (acc) begin
          d_instr = e.w; d_pc = e.pc; d_wnf = 1'b1;
        end else begin
          d_instr = '0; d_wnf = 1'b0;
        end
      end else if (acc) fq.push_back(e);
    end
    if (fq.size() > 2) chk("fifo depth", 32'(fq.size()), 32'd2);
    if (rv) void'(mq.pop_front());
    if (hs) mq.push_back('{hs_addr, cyc + 1 + int'($urandom_range(0, lat_max))});
    @(posedge clk); cyc++; #1;
    check_dec();
  endtask

  initial begin
    logic [31:0] held;
    int          g0;
    bit          found;
    reset_n = 1'b0; imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect_valid = 0; redirect_pc = '0; redirect_arm = 0; stallD = 0; arm_dec = 0;
    cyc = 0; grants = 0; lat_max = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset imem_req", 32'(imem_req), 32'd0);
    chk("reset instrD", instrD, 32'h0);
    chk("reset pcD", pcD, 32'h0);
    chk("reset wnf", 32'(wasNotFlushedD), 32'd0);
    chk("reset armD", 32'(armD), 32'd1);
    reset_n = 1'b1;

    // sequential fetch from RESET_PC
    step(0, 0, '0, 0, 1, 1, 1); chk("addr0", last_addr, 32'h100);
    chk("first bubble", 32'(wasNotFlushedD), 32'd0);
    step(0, 0, '0, 0, 1, 1, 1); chk("addr1", last_addr, 32'h104);
    chk("first instrD", instrD, memf(32'h100));
    chk("first pcD", pcD, 32'h100);
    chk("first armD", 32'(armD), 32'd1);
    step(0, 0, '0, 0, 1, 1, 1); chk("addr2", last_addr, 32'h108);
    chk("second pcD", pcD, 32'h104);

    // stall holds decode and throttles requests
    held = instrD; g0 = grants;
    repeat (5) step(1, 0, '0, 0, 1, 1, 1);
    chk("stall grants<=2", 32'(grants - g0 <= 2), 32'd1);
    chk("stall req low", 32'(last_req), 32'd0);
    chk("stall held", instrD, held);
    repeat (6) step(0, 0, '0, 0, 1, 1, 1);

    // two stale fetches in flight across a redirect
    repeat (4) step(0, 0, '0, 0, 0, 1, 1);
    repeat (2) step(0, 0, '0, 0, 1, 0, 1);
    step(0, 1, 32'h2000, 0, 1, 0, 0);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, '0, 0, 1, 1, 0);
      found = wasNotFlushedD;
    end
    chk("redirect reached", 32'(found), 32'd1);
    chk("redirect pcD", pcD, 32'h2000);
    chk("redirect armD", 32'(armD), 32'd0);

    // redirect coinciding with response and stall
    repeat (3) step(0, 0, '0, 0, 1, 1, 0);
    step(1, 1, 32'h3000, 0, 1, 1, 0);
    chk("redir req low", 32'(last_req), 32'd0);
    chk("redir bubble wnf", 32'(wasNotFlushedD), 32'd0);
    chk("redir bubble instr", instrD, 32'h0);

    // decoder-resolved mode switch, then bubble leaves mode alone
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, '0, 0, 1, 1, 0);
      found = wasNotFlushedD;
    end
    chk("mode test valid", 32'(found), 32'd1);
    step(0, 0, '0, 0, 0, 1, 1);
    chk("arm_dec switch", 32'(armD), 32'd1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, '0, 0, 0, 1, 1);
      found = !wasNotFlushedD;
    end
    chk("drained to bubble", 32'(found), 32'd1);
    step(0, 0, '0, 0, 0, 1, 0);
    chk("bubble keeps mode", 32'(armD), 32'd1);

    // address wrap
    step(0, 1, 32'hFFFF_FFFC, 1, 0, 1, 1);
    step(0, 0, '0, 0, 1, 0, 1); chk("wrap addr0", last_addr, 32'hFFFF_FFFC);
    step(0, 0, '0, 0, 1, 0, 1); chk("wrap addr1", last_addr, 32'h0);
    repeat (4) step(0, 0, '0, 0, 0, 1, 1);

    // randomized traffic, with one asynchronous mid-run reset
    lat_max = 2;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom % 4 == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC);
      step(($urandom % 100) < 30, ($urandom % 100) < 5, rp, 1'($urandom),
           ($urandom % 100) < 70, ($urandom % 100) < 75, 1'($urandom));
      if (i == 1500) begin
        reset_n = 1'b0;
        #1;
        chk("async reset req", 32'(imem_req), 32'd0);
        chk("async reset instrD", instrD, 32'h0);
        chk("async reset pcD", pcD, 32'h0);
        chk("async reset wnf", 32'(wasNotFlushedD), 32'd0);
        chk("async reset armD", 32'(armD), 32'd1);
        model_reset();
        @(posedge clk); cyc++; #1;
        reset_n = 1'b1;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/combi_fetch.md
# combi_fetch

Instruction fetch stage for the combined ARM/RISC-V core. It issues word fetches to instruction memory and buffers up to two returned words. It drives the decode-stage register that feeds the combined decoder: instruction, PC, current ISA mode tag, and a `wasNotFlushed` qualifier. It also tracks the ISA mode the decoder resolves, and discards in-flight fetches after a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `RESET_ARM`, 1'b0, ISA mode after reset (1 = ARM, 0 = RISC-V)

Ports:
- `clk` in 1: single clock; all state on rising edge
- `reset_n` in 1: reset, asynchronous assert, active-low
- `imem_req` out 1: fetch request valid
- `imem_addr` out 32: word-aligned fetch address (bits [1:0] = 0)
- `imem_gnt` in 1: request accepted this cycle when `imem_req & imem_gnt`
- `imem_rvalid` in 1: read data valid; responses in request order, ≥1 cycle after grant
- `imem_rdata` in 32: fetched instruction word
- `redirect_valid` in 1: branch/PCSrc flush from execute
- `redirect_pc` in 32: new fetch address
- `redirect_arm` in 1: ISA mode at redirect target
- `stallD` in 1: hold decode register
- `instrD` out 32: instruction to decoder
- `pcD` out 32: address of `instrD`
- `armD` out 1: mode tag, wired to decoder `armIn`
- `wasNotFlushedD` out 1: 1 = real instruction, 0 = bubble
- `arm_dec` in 1: decoder's resolved mode for the current `instrD`

## Operation
- State:
  - `pc`: next fetch address.
  - `mode`: ISA mode register.
  - `inflight`: 0..2, granted requests without a response.
  - `discard`: 0..2, responses still to drop.
  - 2-entry FIFO holding {word, pc}, with `count` 0..2.
  - Decode register.
- Credit rule: `imem_req = (inflight + count < 2) & ~redirect_valid`; `imem_addr = pc`. FIFO can never overflow, even under indefinite stall.
- On grant: `pc <= pc + 4`; `inflight++`. Address wraps modulo 2^32.
- Response handling: on `imem_rvalid`, `inflight--`.
  - If `discard > 0`: the word is dropped and `discard--`.
  - Otherwise the word is pushed with its fetch PC. FIFO tracks PCs in request order.
- Decode load, when `~stallD`:
  - If the FIFO is non-empty, pop the head into the decode register, `wasNotFlushedD=1`.
  - Else, if an accepted `imem_rvalid` word arrives this cycle, bypass it straight in.
  - Else load a bubble: `instrD=32'h0`, `wasNotFlushedD=0`, `pcD` unchanged.
- When `stallD` is high, the decode register holds.
- Mode update: when `wasNotFlushedD & ~stallD` and no redirect, `mode <= arm_dec`. `armD` always equals `mode`.
- Redirect (highest priority, overrides stall for the decode register):
  - `pc <= redirect_pc`; `mode <= redirect_arm`.
  - FIFO cleared.
  - `discard <= inflight` (minus a response consumed that cycle).
  - Decode register becomes a bubble.
  - No request is issued in the redirect cycle.
- A response in the redirect cycle is dropped regardless of `discard`.

## Timing
- Reset values: `imem_req=0` while `reset_n` low; `pc=RESET_PC`; `mode=RESET_ARM`; `inflight=discard=count=0`; `instrD=0`; `pcD=0`; `wasNotFlushedD=0`; `armD=RESET_ARM`.
- First request is issued in the first cycle after `reset_n` deasserts.
- Latency: grant in cycle t, `rvalid` in t+1, instruction on `instrD` in t+2 (bypass path).
- Steady state with 1-cycle memory and no stall: one instruction per cycle.
- After redirect in cycle r: first request at r+1 to `redirect_pc`. Earliest real instruction at r+3; bubbles in between.
- Full FIFO with `stallD`: `imem_req` stays low until a pop.
- Reset asserted mid-operation clears all state immediately; in-flight responses arriving after reset release are treated as new data. The memory is therefore required to be reset together with this block.

## Structure
- `combi_pkg` holds:
  - `FETCH_DEPTH = 2`.
  - Bubble encoding `INSTR_BUBBLE = 32'h0`.
  - A `fetch_entry_t` struct {instr[31:0], pc[31:0]}.
- Sub-module `combi_fetch_fifo`: 2-entry synchronous FIFO with push, pop, clear, count, and head output.
- Credit/discard counters and the decode register stay in the top level.

## Test plan
- Reset with `RESET_PC=32'h100`, `RESET_ARM=1`, 1-cycle memory, no stall → `imem_addr` 0x100, 0x104, 0x108 on consecutive cycles. `instrD` follows from cycle 2 with `pcD` matching and `armD=1`.
- `stallD` high for 5 cycles after the first instruction → at most two further grants; `imem_req` low; `instrD` held. After release, FIFO words emerge in order with no loss.
- Two requests in flight, `redirect_valid` with `redirect_pc=32'h2000`, `redirect_arm=0` → both stale responses dropped. Next real `instrD` has `pcD=0x2000`, `armD=0`, with bubbles (`wasNotFlushedD=0`) in between.
- Redirect in the same cycle as `imem_rvalid` and `stallD` → response dropped, decode register becomes a bubble, no request in that cycle.
- Decoder returns `arm_dec=1` for a valid instruction while mode is 0 → `armD=1` the next cycle. A bubble with `arm_dec=0` leaves `armD` unchanged.
- `pc=32'hFFFF_FFFC` granted → next `imem_addr=0`.
